// File: rtl/garage_door_pkg.sv
// garage_door_pkg: state encoding shared by the garage door controller and plant,
// plus a helper that sizes the position counter.
package garage_door_pkg;

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] MV_UP    = 2'b01;
    localparam logic [1:0] MV_DN    = 2'b10;
    localparam logic [1:0] FAULT_ST = 2'b11;

    // Smallest counter width able to hold 0..travel_steps inclusive.
    function automatic int min_pos_w(input int travel_steps);
        return $clog2(travel_steps + 1);
    endfunction

endpackage

// File: rtl/garage_door_plant_if.sv
// garage_door_plant_if: motor commands and limit/position feedback between controller and door plant.
interface garage_door_plant_if #(
    parameter int POS_W = 8
);
    logic             UP_M;
    logic             DN_M;
    logic             OBSTRUCT;
    logic             UP_Max;
    logic             DN_Max;
    logic [POS_W-1:0] POSITION;
    logic             MOVING;
    logic             FAULT;

    modport master (
        output UP_M, DN_M, OBSTRUCT,
        input  UP_Max, DN_Max, POSITION, MOVING, FAULT
    );

    modport slave (
        input  UP_M, DN_M, OBSTRUCT,
        output UP_Max, DN_Max, POSITION, MOVING, FAULT
    );
endinterface

// File: rtl/garage_door_plant_prescaler.sv
// door_step_prescaler: divides active motor drive cycles into position steps.
// CLR discards the held count; when EN is also high counting proceeds from zero.
module door_step_prescaler #(
    parameter int STEP_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);
    localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d, base;

    always_comb begin
        base  = CLR ? '0 : cnt_q;
        TICK  = EN && base == LAST;
        cnt_d = TICK ? '0 : EN ? base + 1'b1 : base;
    end

    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/garage_door_plant.sv
// garage_door_plant: integrates door position from motor commands and decodes limit switches,
// with a sticky fault on conflicting commands and an obstruction input that freezes motion.
module garage_door_plant
    import garage_door_pkg::*;
#(
    parameter int TRAVEL_STEPS = 16,
    parameter int STEP_DIV     = 4,
    parameter int POS_W        = 8,
    parameter bit INIT_OPEN    = 1'b0
) (
    input logic CLK,
    input logic RST,
    garage_door_plant_if.slave bus
);
    localparam logic [POS_W-1:0] POS_TOP = POS_W'(TRAVEL_STEPS);
    localparam logic [POS_W-1:0] POS_RST = INIT_OPEN ? POS_TOP : '0;

    logic [1:0]       state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             cmd_mv, at_lim_d, mv_q, at_lim_q, en, clr, tick;

    door_step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
        .CLK (CLK),
        .RST (RST),
        .EN  (en),
        .CLR (clr),
        .TICK(tick)
    );

    // The 2-bit encoding is exactly {DN_M, UP_M}; FAULT_ST latches until reset.
    always_comb begin
        state_d  = state_q == FAULT_ST ? FAULT_ST : {bus.DN_M, bus.UP_M};
        cmd_mv   = state_d == MV_UP || state_d == MV_DN;
        at_lim_d = state_d == MV_UP ? pos_q == POS_TOP : pos_q == '0;
        en       = cmd_mv && !bus.OBSTRUCT && !at_lim_d;
        clr      = state_d != state_q || !cmd_mv || at_lim_d;
        pos_d    = !tick ? pos_q : state_d == MV_UP ? pos_q + 1'b1 : pos_q - 1'b1;
        mv_q     = state_q == MV_UP || state_q == MV_DN;
        at_lim_q = state_q == MV_UP ? pos_q == POS_TOP : pos_q == '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pos_q   <= POS_RST;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    assign bus.UP_Max   = pos_q == POS_TOP;
    assign bus.DN_Max   = pos_q == '0;
    assign bus.POSITION = pos_q;
    assign bus.MOVING   = mv_q && !bus.OBSTRUCT && !at_lim_q;
    assign bus.FAULT    = state_q == FAULT_ST;
endmodule

// File: tb/tb_garage_door_plant.sv
// tb_garage_door_plant: directed checks of three plant configurations driven by hand-computed vectors.
module tb_garage_door_plant;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cnt;

    always #5 clk = ~clk;

    garage_door_plant_if #(.POS_W(8)) ia ();
    garage_door_plant_if #(.POS_W(8)) ib ();
    garage_door_plant_if #(.POS_W(8)) ic ();

    garage_door_plant #(.TRAVEL_STEPS(4), .STEP_DIV(2), .POS_W(8), .INIT_OPEN(1'b0))
        dut_a (.CLK(clk), .RST(rst_a), .bus(ia));
    garage_door_plant #(.TRAVEL_STEPS(4), .STEP_DIV(4), .POS_W(8), .INIT_OPEN(1'b1))
        dut_b (.CLK(clk), .RST(rst_b), .bus(ib));
    garage_door_plant #(.TRAVEL_STEPS(8), .STEP_DIV(3), .POS_W(8), .INIT_OPEN(1'b1))
        dut_c (.CLK(clk), .RST(rst_c), .bus(ic));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        {ia.UP_M, ia.DN_M, ia.OBSTRUCT} = 3'b000;
        {ib.UP_M, ib.DN_M, ib.OBSTRUCT} = 3'b000;
        {ic.UP_M, ic.DN_M, ic.OBSTRUCT} = 3'b000;
        {rst_a, rst_b, rst_c} = 3'b111;
        step(2);
        {rst_a, rst_b, rst_c} = 3'b000;
        chk("a_rst_pos", ia.POSITION, 0);
        chk("a_rst_dnmax", ia.DN_Max, 1);
        chk("a_rst_upmax", ia.UP_Max, 0);
        chk("a_rst_fault", ia.FAULT, 0);
        chk("a_rst_moving", ia.MOVING, 0);
        // raise: steps land on edges 2,4,6,8
        ia.UP_M = 1'b1;
        step(1);
        chk("a_up_e1_pos", ia.POSITION, 0);
        chk("a_up_e1_moving", ia.MOVING, 1);
        step(1);
        chk("a_up_e2_pos", ia.POSITION, 1);
        chk("a_up_e2_dnmax", ia.DN_Max, 0);
        step(5);
        chk("a_up_e7_pos", ia.POSITION, 3);
        step(1);
        chk("a_up_e8_pos", ia.POSITION, 4);
        chk("a_up_e8_upmax", ia.UP_Max, 1);
        chk("a_up_e8_moving", ia.MOVING, 0);
        step(3);
        chk("a_up_sat_pos", ia.POSITION, 4);
        // lower with an idle gap that discards the partial step
        ia.UP_M = 1'b0;
        ia.DN_M = 1'b1;
        step(1);
        chk("a_dn_e1_pos", ia.POSITION, 4);
        step(1);
        chk("a_dn_e2_pos", ia.POSITION, 3);
        step(1);
        ia.DN_M = 1'b0;
        step(1);
        chk("a_idle_pos", ia.POSITION, 3);
        chk("a_idle_moving", ia.MOVING, 0);
        ia.DN_M = 1'b1;
        step(1);
        chk("a_restart_e1_pos", ia.POSITION, 3);
        step(1);
        chk("a_restart_e2_pos", ia.POSITION, 2);
        // conflicting commands at position 2
        ia.UP_M = 1'b1;
        step(1);
        chk("a_fault_set", ia.FAULT, 1);
        chk("a_fault_pos", ia.POSITION, 2);
        ia.UP_M = 1'b0;
        step(3);
        chk("a_fault_dn_pos", ia.POSITION, 2);
        ia.DN_M = 1'b0;
        ia.UP_M = 1'b1;
        step(3);
        chk("a_fault_up_pos", ia.POSITION, 2);
        chk("a_fault_sticky", ia.FAULT, 1);
        ia.UP_M = 1'b0;
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        chk("a_rerst_fault", ia.FAULT, 0);
        chk("a_rerst_pos", ia.POSITION, 0);
        chk("a_rerst_dnmax", ia.DN_Max, 1);

        // obstruction freezes the prescaler mid-step
        chk("b_rst_pos", ib.POSITION, 4);
        chk("b_rst_upmax", ib.UP_Max, 1);
        ib.DN_M = 1'b1;
        step(2);
        chk("b_pre_obs_pos", ib.POSITION, 4);
        ib.OBSTRUCT = 1'b1;
        step(10);
        chk("b_obs_pos", ib.POSITION, 4);
        chk("b_obs_moving", ib.MOVING, 0);
        ib.OBSTRUCT = 1'b0;
        step(1);
        chk("b_rel_e1_pos", ib.POSITION, 4);
        chk("b_rel_e1_moving", ib.MOVING, 1);
        step(1);
        chk("b_rel_e2_pos", ib.POSITION, 3);
        ib.DN_M = 1'b0;

        // full travel closes then opens in 24 edges each
        ic.DN_M = 1'b1;
        cnt = 0;
        while (!ic.DN_Max && cnt < 100) begin
            step(1);
            cnt++;
        end
        chk("c_close_edges", cnt, 24);
        chk("c_close_pos", ic.POSITION, 0);
        ic.DN_M = 1'b0;
        ic.UP_M = 1'b1;
        cnt = 0;
        while (!ic.UP_Max && cnt < 100) begin
            step(1);
            cnt++;
        end
        chk("c_open_edges", cnt, 24);
        chk("c_open_pos", ic.POSITION, 8);
        chk("c_no_fault", ic.FAULT, 0);
        // reset mid-descent snaps back to fully open
        ic.UP_M = 1'b0;
        ic.DN_M = 1'b1;
        step(10);
        chk("c_mid_pos", ic.POSITION, 5);
        rst_c = 1'b1;
        step(1);
        rst_c = 1'b0;
        chk("c_rst_pos", ic.POSITION, 8);
        chk("c_rst_upmax", ic.UP_Max, 1);
        chk("c_rst_dnmax", ic.DN_Max, 0);
        step(2);
        chk("c_after_e2_pos", ic.POSITION, 8);
        step(1);
        chk("c_after_e3_pos", ic.POSITION, 7);
        ic.DN_M = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/garage_door_plant.md
Name: garage_door_plant

Overview:
Behavioural/synthesizable model of the physical garage door driven by the garage door controller's motor commands.
- Consumes UP_M / DN_M.
- Integrates door position over time.
- Produces the UP_Max / DN_Max limit-switch signals the controller consumes.

Closes the loop for system-level simulation and FPGA demo boards. Also flags illegal motor commands and models an obstruction that stalls the door.

Parameters:
- TRAVEL_STEPS, 16, position steps from fully closed (0) to fully open (TRAVEL_STEPS); must be >= 2.
- STEP_DIV, 4, clock cycles of active motor drive per position step; must be >= 1.
- POS_W, 8, width of POSITION; 2**POS_W > TRAVEL_STEPS.
- INIT_OPEN, 0, 1 = door resets fully open, 0 = door resets fully closed.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- UP_M  input  1  motor raise command from controller
- DN_M  input  1  motor lower command from controller
- OBSTRUCT  input  1  door mechanically blocked; motion frozen while high
- UP_Max  output  1  upper limit switch, high when POSITION == TRAVEL_STEPS
- DN_Max  output  1  lower limit switch, high when POSITION == 0
- POSITION  output  POS_W  current door position, 0 = closed
- MOVING  output  1  high in any cycle in which the step prescaler is advancing
- FAULT  output  1  sticky: UP_M and DN_M were sampled high together

Behaviour:
- Reset (RST high at an edge):
  - POSITION = INIT_OPEN ? TRAVEL_STEPS : 0; prescaler = 0; state = IDLE; FAULT = 0.
  - Reset mid-travel discards the partial step and snaps POSITION to the reset value.
- UP_Max and DN_Max are decoded combinationally from the registered POSITION only, so they are glitch-free and valid from the cycle after reset.
- MOVING is decoded from the registered state and inputs: high iff state is MV_UP or MV_DN, OBSTRUCT = 0, and the door is not at the limit in the drive direction.
- State register, sampled every edge:
  - IDLE: UP_M = DN_M = 0.
  - MV_UP: UP_M = 1, DN_M = 0.
  - MV_DN: DN_M = 1, UP_M = 0.
  - FAULT_ST: UP_M = DN_M = 1.
- FAULT_ST is absorbing until RST. FAULT = 1 from the edge that sampled both commands high. POSITION is frozen while in FAULT_ST.
- Step prescaler (count 0..STEP_DIV-1), per edge while in MV_UP or MV_DN:
  - If the direction changed since the previous edge, or the previous state was IDLE, the prescaler restarts at 0 before counting.
  - If OBSTRUCT = 1: prescaler and POSITION hold.
  - Else if at the limit in the drive direction (POSITION == TRAVEL_STEPS for up, 0 for down): no change; prescaler held at 0; commanding past a limit is legal and saturates.
  - Else if prescaler == STEP_DIV-1: prescaler <= 0 and POSITION <= POSITION ±1.
  - Else prescaler <= prescaler + 1.
- Latency:
  - With STEP_DIV = N, a command first sampled at edge k produces the first POSITION change at edge k+N-1.
  - Full travel takes TRAVEL_STEPS*N edges of uninterrupted command.
- IDLE: prescaler cleared to 0; POSITION holds. A partial step is lost on any stop or reversal.
- OBSTRUCT: does not affect limits or FAULT. Releasing it resumes counting from the held prescaler value.
- No arithmetic wrap: POSITION never leaves 0..TRAVEL_STEPS.

Decomposition:
- garage_door_pkg holds the shared 2-bit state encoding: IDLE=2'b00, MV_UP=2'b01, MV_DN=2'b10, FAULT_ST=2'b11.
  - This matches the controller's existing state values; the controller is migrated to import it.
- garage_door_pkg also holds a function computing the minimum POS_W from TRAVEL_STEPS.
- One sub-module, door_step_prescaler, with ports CLK, RST, EN, CLR, TICK:
  - The cycle-divider counter.
  - CLR has priority over EN.
  - TICK is a combinational pulse when EN is high and count == STEP_DIV-1.
- The top level owns the state register, position counter, and limit decode.

Test Plan:
1. TRAVEL_STEPS=4, STEP_DIV=2, INIT_OPEN=0: release RST, hold UP_M=1 -> DN_Max=1 initially; POSITION 1 at 2nd edge, 4 at 8th edge; UP_Max=1, MOVING=0 thereafter; POSITION stays 4 with UP_M still high.
2. From POSITION=4: hold DN_M for 3 edges, then 1 idle edge, then DN_M again -> POSITION 3 after edge 2; partial step lost at idle; next decrement occurs 2 edges after the restart.
3. Lowering from 4 with STEP_DIV=4: assert OBSTRUCT for 10 cycles after 2 drive edges -> POSITION and prescaler frozen, MOVING=0; after release, POSITION reaches 3 two edges later.
4. UP_M=DN_M=1 for one edge at POSITION=2 -> FAULT=1 next cycle; POSITION stays 2 under any further commands; RST -> FAULT=0, POSITION=0.
5. Closed loop with the garage door controller (TRAVEL_STEPS=8, STEP_DIV=3): pulse Activate from closed -> door opens to 8 in 24 drive edges and controller returns to IDLE on UP_Max; pulse again -> closes to 0, DN_Max=1; FAULT never set.
6. INIT_OPEN=1: assert RST mid-descent at POSITION=5 -> next cycle POSITION=8, UP_Max=1, DN_Max=0, prescaler 0.
